hash_msg_feeder: RTL and testbench

Host-side driver for the team's 32-bit DES-S-box hash core. It buffers one complete message frame from a byte-stream host interface, then drives the core's M_valid/message/counter protocol as one contiguous burst. It waits for the core's hash_ready, captures digest_out, and returns the digest to the host through a valid/ready handshake. It sits between the system byte source and full_hash_des_box.

---
 rtl/hash_msg_feeder_pkg.sv | 8 +
 rtl/hash_msg_feeder_if.sv | 37 +++
 rtl/hash_msg_feeder_frame_buf.sv | 28 ++
 rtl/hash_msg_feeder.sv | 150 +++++++++++++++
 tb/tb_hash_msg_feeder.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hash_msg_feeder_pkg.sv
// Shared state type and bus widths for the hash-core message feeder.
package hash_feeder_pkg;
  typedef enum logic [1:0] {LOAD, SEND, WAIT, HOLD} feeder_state_t;

  localparam int MSG_W    = 8;
  localparam int DIGEST_W = 32;
  localparam int CNT_W    = 64;
endpackage

// File: rtl/hash_msg_feeder_if.sv
// Host byte stream, hash core and digest return signals of the message feeder.
interface hash_msg_feeder_if
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH = 64
);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic                in_valid;
  logic                in_ready;
  logic [MSG_W-1:0]    in_data;
  logic                in_last;
  logic                in_empty;
  logic                M_valid;
  logic [MSG_W-1:0]    message;
  logic [CNT_W-1:0]    counter;
  logic                hash_ready;
  logic [DIGEST_W-1:0] digest_in;
  logic                dig_valid;
  logic                dig_ready;
  logic [DIGEST_W-1:0] dig_data;
  logic [LEN_W-1:0]    dig_len;
  logic                ovf_err;
  logic                timeout_err;

  modport master (
    input  in_valid, in_data, in_last, in_empty, hash_ready, digest_in, dig_ready,
    output in_ready, M_valid, message, counter, dig_valid, dig_data, dig_len,
           ovf_err, timeout_err
  );

  modport slave (
    output in_valid, in_data, in_last, in_empty, hash_ready, digest_in, dig_ready,
    input  in_ready, M_valid, message, counter, dig_valid, dig_data, dig_len,
           ovf_err, timeout_err
  );
endinterface

// File: rtl/hash_msg_feeder_frame_buf.sv
// Frame byte store: one write port, one registered read port that returns 0 when not enabled.
module hash_frame_buf
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [MSG_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [MSG_W-1:0] rdata
);
  logic [MSG_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // rdata drives the core's message bus directly, so it idles at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= re ? mem[raddr] : '0;
  end
endmodule

// File: rtl/hash_msg_feeder.sv
// Buffers one host frame, bursts it into the hash core, returns the digest to the host.
// Optional WAIT watchdog: define HASH_FEEDER_TIMEOUT_EN.
module hash_msg_feeder
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst_n,
  hash_msg_feeder_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  feeder_state_t       state;
  logic [LW-1:0]       len, rd_ptr, burst_last;
  logic                ovf, armed, seen_low;
  logic                in_ready_r, m_valid_r, dig_valid_r, ovf_err_r;
  logic [CNT_W-1:0]    counter_r;
  logic [DIGEST_W-1:0] dig_data_r;
  logic [LW-1:0]       dig_len_r;
  logic                beat, has_byte, drop, buf_we, buf_re, capture, expire;
  logic [MSG_W-1:0]    buf_rdata;

  assign beat       = bus.in_valid && in_ready_r;
  assign has_byte   = !(bus.in_empty && bus.in_last);
  assign drop       = beat && has_byte && (len == DEPTH_L);
  assign buf_we     = beat && has_byte && (len != DEPTH_L);
  assign burst_last = (len == '0) ? '0 : len - 1'b1;
  assign buf_re     = (state == SEND) && (len != '0);
  // A stale hash_ready from the previous frame is ignored until a low is seen
  assign capture    = (state == WAIT) && bus.hash_ready && seen_low;

  hash_frame_buf #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .waddr (len[AW-1:0]),
    .wdata (bus.in_data),
    .re    (buf_re),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (buf_rdata)
  );

`ifdef HASH_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_err_r;

  assign expire = (state == WAIT) && !capture && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt      <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      wait_cnt      <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      timeout_err_r <= expire;
    end
  end

  assign bus.timeout_err = timeout_err_r;
`else
  logic unused_timeout;
  assign unused_timeout  = (TIMEOUT > 0);
  assign expire          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      len         <= '0;
      rd_ptr      <= '0;
      ovf         <= 1'b0;
      armed       <= 1'b0;
      seen_low    <= 1'b0;
      in_ready_r  <= 1'b1;
      m_valid_r   <= 1'b0;
      counter_r   <= '0;
      dig_valid_r <= 1'b0;
      dig_data_r  <= '0;
      dig_len_r   <= '0;
      ovf_err_r   <= 1'b0;
    end else begin
      ovf_err_r <= 1'b0;
      if (m_valid_r) armed <= 1'b1;
      if (armed && !bus.hash_ready) seen_low <= 1'b1;
      unique case (state)
        LOAD: if (beat) begin
          if (buf_we) len <= len + 1'b1;
          if (drop)   ovf <= 1'b1;
          if (bus.in_last) begin
            if (ovf || drop) begin
              ovf_err_r <= 1'b1;
              ovf       <= 1'b0;
              len       <= '0;
            end else begin
              state      <= SEND;
              in_ready_r <= 1'b0;
              rd_ptr     <= '0;
              armed      <= 1'b0;
              seen_low   <= 1'b0;
              counter_r  <= CNT_W'(len + LW'(buf_we));
            end
          end
        end
        SEND: begin
          m_valid_r <= 1'b1;
          rd_ptr    <= rd_ptr + 1'b1;
          if (rd_ptr == burst_last) state <= WAIT;
        end
        WAIT: begin
          m_valid_r <= 1'b0;
          if (capture) begin
            state       <= HOLD;
            dig_valid_r <= 1'b1;
            dig_data_r  <= bus.digest_in;
            dig_len_r   <= len;
            counter_r   <= '0;
          end else if (expire) begin
            state      <= LOAD;
            in_ready_r <= 1'b1;
            len        <= '0;
            counter_r  <= '0;
          end
        end
        HOLD: if (bus.dig_ready) begin
          state       <= LOAD;
          dig_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          len         <= '0;
          rd_ptr      <= '0;
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.M_valid   = m_valid_r;
  assign bus.message   = buf_rdata;
  assign bus.counter   = counter_r;
  assign bus.dig_valid = dig_valid_r;
  assign bus.dig_data  = dig_data_r;
  assign bus.dig_len   = dig_len_r;
  assign bus.ovf_err   = ovf_err_r;
endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder with a behavioural hash-core timing model.
module tb_hash_msg_feeder;
  import hash_feeder_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hash_msg_feeder_if #(.DEPTH(DEPTH)) bus ();
  hash_msg_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
    return (h ^ {24'b0, b}) * 32'h0100_0193;
  endfunction

  function automatic logic [31:0] exp_digest(input logic [79:0] d, input int n);
    logic [31:0] h = 32'h811C_9DC5;
    for (int i = 0; i < n; i++) h = fnv_step(h, d[8*i +: 8]);
    return h ^ n;
  endfunction

  // Core model: drops hash_ready at t0+1, raises it with the digest at t0+len+2
  int cyc = 0;
  int k = -1;
  int mlen = 0;
  logic [31:0] h = '0;
  logic mv_q = 1'b0;
  logic hr_tie_low = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = -1;
      mv_q = 1'b0;
      bus.hash_ready <= 1'b0;
      bus.digest_in  <= '0;
    end else begin
      if (bus.M_valid && !mv_q) begin
        k = 0;
        mlen = int'(bus.counter);
        h = 32'h811C_9DC5;
      end else if (k >= 0) begin
        k++;
      end
      if (bus.M_valid && k >= 0 && k < mlen) h = fnv_step(h, bus.message);
      mv_q = bus.M_valid;
      if (k == 0) begin
        bus.hash_ready <= 1'b0;
      end else if (k >= 0 && k + 1 == mlen + 2) begin
        bus.hash_ready <= !hr_tie_low;
        bus.digest_in  <= h ^ mlen;
        k = -1;
      end
    end
  end

  logic [7:0] mon_bytes[$];
  int mon_bursts = 0, mon_t0 = 0, ovf_cnt = 0, tmo_cnt = 0, idle_msg_bad = 0, rdy_bad = 0;
  logic [63:0] mon_cnt = '0;
  logic mon_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.M_valid) begin
      if (!mon_prev) begin
        mon_bursts++;
        mon_t0 = cyc;
        mon_cnt = bus.counter;
      end
      mon_bytes.push_back(bus.message);
    end else if (bus.message !== 8'h00) begin
      idle_msg_bad++;
    end
    if ((bus.M_valid || bus.dig_valid) && bus.in_ready) rdy_bad++;
    if (bus.ovf_err) ovf_cnt++;
    if (bus.timeout_err) tmo_cnt++;
    mon_prev = bus.M_valid;
  end

  typedef struct packed {
    logic [79:0] data;
    logic [3:0]  n;
    logic        empty_last;
    logic [3:0]  gap;
    logic [3:0]  stall;
    logic [7:0]  exp_len;
    logic [7:0]  exp_burst;
    logic        ovf;
  } vec_t;

  vec_t vt [8];

  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_empty = empty;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL in_ready_wait: got 0 expected 1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic run_vec(input vec_t v);
    int b0, o0, n, lat;
    logic [31:0] dd;
    logic [3:0]  dl;
    logic stable;
    b0 = mon_bursts;
    o0 = ovf_cnt;
    mon_bytes.delete();
    for (int i = 0; i < int'(v.n); i++) begin
      repeat ($urandom_range(0, int'(v.gap))) @(negedge clk);
      send_beat(v.data[8*i +: 8], (i == int'(v.n) - 1) && !v.empty_last, 1'b0);
    end
    if (v.empty_last) send_beat(8'h00, 1'b1, 1'b1);
    if (v.ovf) begin
      repeat (4) @(negedge clk);
      chk("ovf_pulse_count", 64'(ovf_cnt - o0), 64'd1);
      chk("ovf_no_burst", 64'(mon_bursts - b0), 64'd0);
      chk("ovf_in_ready", 64'(bus.in_ready), 64'd1);
    end else begin
      n = 0;
      while (!bus.dig_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      lat = cyc - mon_t0;
      chk("dig_valid_seen", 64'(bus.dig_valid), 64'd1);
      chk("burst_count", 64'(mon_bursts - b0), 64'd1);
      chk("burst_len", 64'(mon_bytes.size()), 64'(v.exp_burst));
      for (int i = 0; i < int'(v.exp_burst); i++)
        if (i < mon_bytes.size()) chk("message_byte", 64'(mon_bytes[i]), 64'(v.data[8*i +: 8]));
      chk("counter", mon_cnt, 64'(v.exp_len));
      chk("dig_latency", 64'(lat), 64'(int'(v.exp_len) + 3));
      chk("dig_data", 64'(bus.dig_data), 64'(exp_digest(v.data, int'(v.exp_len))));
      chk("dig_len", 64'(bus.dig_len), 64'(v.exp_len));
      dd = bus.dig_data;
      dl = bus.dig_len;
      stable = 1'b1;
      repeat (int'(v.stall)) begin
        @(negedge clk);
        if (!bus.dig_valid || bus.dig_data !== dd || bus.dig_len !== dl) stable = 1'b0;
      end
      if (v.stall != 0) chk("dig_stable_in_stall", 64'(stable), 64'd1);
      bus.dig_ready = 1'b1;
      @(negedge clk);
      bus.dig_ready = 1'b0;
      chk("dig_valid_drop", 64'(bus.dig_valid), 64'd0);
    end
  endtask

  initial begin
    int n, mv;
    vt[0] = '{data: 80'h61,                   n: 1,  empty_last: 0, gap: 0, stall: 0,  exp_len: 1, exp_burst: 1, ovf: 0};
    vt[1] = '{data: 80'h0,                    n: 0,  empty_last: 1, gap: 0, stall: 0,  exp_len: 0, exp_burst: 1, ovf: 0};
    vt[2] = '{data: 80'h6F6C6C6568,           n: 5,  empty_last: 0, gap: 3, stall: 2,  exp_len: 5, exp_burst: 5, ovf: 0};
    vt[3] = '{data: 80'h6968,                 n: 2,  empty_last: 0, gap: 0, stall: 10, exp_len: 2, exp_burst: 2, ovf: 0};
    vt[4] = '{data: 80'h0807060504030201,     n: 8,  empty_last: 0, gap: 1, stall: 0,  exp_len: 8, exp_burst: 8, ovf: 0};
    vt[5] = '{data: 80'h0A090807060504030201, n: 10, empty_last: 0, gap: 0, stall: 0,  exp_len: 0, exp_burst: 0, ovf: 1};
    vt[6] = '{data: 80'h6B6F,                 n: 2,  empty_last: 0, gap: 0, stall: 0,  exp_len: 2, exp_burst: 2, ovf: 0};
    vt[7] = '{data: 80'h7978,                 n: 2,  empty_last: 1, gap: 2, stall: 3,  exp_len: 2, exp_burst: 2, ovf: 0};

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.in_empty  = 1'b0;
    bus.dig_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_M_valid", 64'(bus.M_valid), 64'd0);
    chk("rst_message", 64'(bus.message), 64'd0);
    chk("rst_counter", bus.counter, 64'd0);
    chk("rst_dig_valid", 64'(bus.dig_valid), 64'd0);
    chk("rst_dig_data", 64'(bus.dig_data), 64'd0);
    chk("rst_dig_len", 64'(bus.dig_len), 64'd0);
    chk("rst_ovf_err", 64'(bus.ovf_err), 64'd0);
    chk("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Reset asserted during the third M_valid cycle of a burst
    for (int i = 0; i < 5; i++) send_beat(vt[2].data[8*i +: 8], i == 4, 1'b0);
    n = 0;
    mv = 0;
    while (mv < 3 && n < 50) begin
      @(negedge clk);
      if (bus.M_valid) mv++;
      n++;
    end
    chk("mid_send_reached", 64'(mv), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_M_valid", 64'(bus.M_valid), 64'd0);
    chk("midrst_message", 64'(bus.message), 64'd0);
    chk("midrst_counter", bus.counter, 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_dig_valid", 64'(bus.dig_valid), 64'd0);
    chk("midrst_dig_data", 64'(bus.dig_data), 64'd0);
    chk("midrst_dig_len", 64'(bus.dig_len), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 5; i < 8; i++) run_vec(vt[i]);

`ifdef HASH_FEEDER_TIMEOUT_EN
    hr_tie_low = 1'b1;
    send_beat(8'h61, 1'b1, 1'b0);
    n = 0;
    while (!bus.timeout_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_seen", 64'(bus.timeout_err), 64'd1);
    chk("timeout_latency", 64'(cyc - mon_t0), 64'(TIMEOUT));
    chk("timeout_no_dig", 64'(bus.dig_valid), 64'd0);
    @(negedge clk);
    chk("timeout_in_ready", 64'(bus.in_ready), 64'd1);
    chk("timeout_pulse_count", 64'(tmo_cnt), 64'd1);
    hr_tie_low = 1'b0;
    run_vec(vt[0]);
`else
    chk("timeout_err_tied", 64'(tmo_cnt), 64'd0);
`endif

    chk("idle_message_zero", 64'(idle_msg_bad), 64'd0);
    chk("in_ready_low_when_busy", 64'(rdy_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
